memory_stage: RTL

MEMORY_STAGE -- requirements
Module: memory_stage

---
 rtl/memory_stage.sv | 101 ++++++++++
 1 files changed

// File: rtl/memory_stage.sv
// Y86-64 memory stage: 8-byte little-endian data memory plus the W pipeline register.
// m_* outputs are combinational; W_* outputs are registered one cycle later.
module memory_stage #(
  parameter int          MEM_BYTES = 1024,
  parameter logic [3:0]  STAT_AOK  = 4'd1,
  parameter logic [3:0]  STAT_HLT  = 4'd2,
  parameter logic [3:0]  STAT_ADR  = 4'd3,
  parameter logic [3:0]  STAT_INS  = 4'd4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  M_stat,
  input  logic [3:0]  M_icode,
  input  logic        M_cnd,
  input  logic [63:0] M_valE,
  input  logic [63:0] M_valA,
  input  logic [3:0]  M_dstE,
  input  logic [3:0]  M_dstM,
  input  logic        W_stall,
  input  logic        W_bubble,
  output logic [3:0]  m_stat,
  output logic [63:0] m_valM,
  output logic [3:0]  W_stat,
  output logic [3:0]  W_icode,
  output logic [63:0] W_valE,
  output logic [63:0] W_valM,
  output logic [3:0]  W_dstE,
  output logic [3:0]  W_dstM
);

  localparam int          AW       = $clog2(MEM_BYTES);
  localparam logic [63:0] MAX_ADDR = 64'(MEM_BYTES - 8);

  logic [7:0]    mem [MEM_BYTES] = '{default: 8'h00};
  logic [63:0]   addr;
  logic [63:0]   rdata;
  logic [AW-1:0] idx;
  logic          is_read;
  logic          is_write;
  logic          addr_ok;
  logic          wr_en;

  // M_cnd travels with the instruction but this stage has no use for it.
  logic unused_ok;
  assign unused_ok = ^{M_cnd, STAT_HLT, STAT_INS};

  always_comb begin
    addr     = '0;
    is_read  = 1'b0;
    is_write = 1'b0;
    case (M_icode)
      4'h4, 4'h8, 4'hA: begin addr = M_valE; is_write = 1'b1; end
      4'h5:             begin addr = M_valE; is_read  = 1'b1; end
      4'h9, 4'hB:       begin addr = M_valA; is_read  = 1'b1; end
      default: ;
    endcase
  end

  // Full 64-bit compare so huge addresses cannot wrap into range.
  assign addr_ok = (addr <= MAX_ADDR);
  assign idx     = addr[AW-1:0];

  always_comb begin
    rdata = '0;
    for (int i = 0; i < 8; i++) begin
      rdata[8*i +: 8] = mem[idx + AW'(i)];
    end
  end

  assign m_stat = ((is_read || is_write) && !addr_ok) ? STAT_ADR : M_stat;
  assign m_valM = (is_read && addr_ok) ? rdata : '0;
  assign wr_en  = is_write && addr_ok && (M_stat == STAT_AOK) && !reset;

  // Stores ignore W_stall: a stalled W register must not lose the write.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int i = 0; i < 8; i++) begin
        mem[idx + AW'(i)] <= M_valA[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset || W_bubble) begin
      W_stat  <= STAT_AOK;
      W_icode <= 4'h1;
      W_valE  <= '0;
      W_valM  <= '0;
      W_dstE  <= 4'hF;
      W_dstM  <= 4'hF;
    end else if (!W_stall) begin
      W_stat  <= m_stat;
      W_icode <= M_icode;
      W_valE  <= M_valE;
      W_valM  <= m_valM;
      W_dstE  <= M_dstE;
      W_dstM  <= M_dstM;
    end
  end

endmodule
